// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmu_pkg
// Purpose : Shared constants and types for the MMU memory responder:
//           access-width codes, FSM state encoding and a read-extension
//           helper used by the data alignment logic.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mmu_pkg;

    // Access width codes carried on mmu_mem_data_width.
    // Code 2'b11 is not listed here; it is handled as a word access.
    localparam logic [1:0] MMU_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] MMU_WIDTH_HALF = 2'b01;
    localparam logic [1:0] MMU_WIDTH_WORD = 2'b10;

    // Largest supported wait-state count (the wait counter is 4 bits wide).
    localparam int unsigned MMU_LATENCY_MAX = 15;

    // Responder FSM states.
    typedef enum logic [1:0] {
        MMU_IDLE   = 2'd0,
        MMU_WAIT   = 2'd1,
        MMU_ACCESS = 2'd2,
        MMU_RESP   = 2'd3
    } mmu_state_e;

    // Right-aligned byte/half value extended to 32 bits. For a byte only
    // v[7:0] is meaningful; sgn selects sign- versus zero-extension.
    function automatic logic [31:0] mmu_extend(input logic [15:0] v,
                                               input logic        is_half,
                                               input logic        sgn);
        if (is_half) begin
            mmu_extend = {{16{sgn & v[15]}}, v};
        end else begin
            mmu_extend = {{24{sgn & v[7]}}, v[7:0]};
        end
    endfunction

endpackage : mmu_pkg
`default_nettype wire

// File: rtl/mmu_data_align.sv
`default_nettype none
// ============================================================================
// Module  : mmu_data_align
// Purpose : Combinational lane steering for little-endian byte/half/word
//           accesses on a 32-bit memory word.
// Ports   : width_i       access width code
//           signed_i      1 = sign-extend byte/half reads
//           addr_lo_i     byte address bits [1:0]
//           mem_word_i    current content of the addressed word
//           data_in_i     right-aligned write data
//           rd_data_o     right-aligned, extended read value
//           wr_word_o     word with the write data merged into its lane(s)
//           misaligned_o  access violates its natural alignment
// Revision: 1.0 - initial release
// ============================================================================
module mmu_data_align
    import mmu_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] mem_word_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] rd_data_o,
    output logic [31:0] wr_word_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane 0 is the least significant byte/half (little-endian).
    assign byte_lane = mem_word_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

    always_comb begin
        rd_data_o    = 32'd0;
        wr_word_o    = mem_word_i;
        misaligned_o = 1'b0;

        case (width_i)
            MMU_WIDTH_BYTE: begin
                rd_data_o = mmu_extend({8'h00, byte_lane}, 1'b0, signed_i);
                wr_word_o[{addr_lo_i, 3'b000} +: 8] = data_in_i[7:0];
            end
            MMU_WIDTH_HALF: begin
                if (addr_lo_i[0]) begin
                    misaligned_o = 1'b1;
                end else begin
                    rd_data_o = mmu_extend(half_lane, 1'b1, signed_i);
                    wr_word_o[{addr_lo_i[1], 4'b0000} +: 16] = data_in_i[15:0];
                end
            end
            // Word and the reserved code 2'b11 share word behaviour;
            // sign control is irrelevant for a full word.
            default: begin
                if (addr_lo_i != 2'b00) begin
                    misaligned_o = 1'b1;
                end else begin
                    rd_data_o = mem_word_i;
                    wr_word_o = data_in_i;
                end
            end
        endcase
    end

endmodule : mmu_data_align
`default_nettype wire

// File: rtl/mmu.sv
`default_nettype none
// ============================================================================
// Module  : mmu
// Purpose : Memory-side responder for the CPU MMU request interface. Takes
//           one level-held read/write request at a time, inserts LATENCY
//           wait states, performs a byte/half/word access on a little-endian
//           word array and returns a one-cycle mmu_mem_ready pulse.
// Ports   : clk                  clock
//           reset_n              asynchronous active-low reset
//           mmu_read_enable      read request (level)
//           mmu_write_enable     write request (level), wins over read
//           mmu_mem_signed_read  sign-extend byte/half reads
//           mmu_mem_data_width   access width code
//           mmu_address          byte address
//           mmu_data_in          right-aligned write data
//           mmu_data_out         right-aligned, extended read data
//           mmu_mem_ready        one-cycle completion pulse
//           mmu_misaligned       completion was a suppressed misaligned access
// Revision: 1.0 - initial release
// ============================================================================
module mmu
    import mmu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter string       INIT_FILE       = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mmu_read_enable,
    input  logic        mmu_write_enable,
    input  logic        mmu_mem_signed_read,
    input  logic [1:0]  mmu_mem_data_width,
    input  logic [31:0] mmu_address,
    input  logic [31:0] mmu_data_in,
    output logic [31:0] mmu_data_out,
    output logic        mmu_mem_ready,
    output logic        mmu_misaligned
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam int unsigned ADR_W = IDX_W + 2;

    // Wait counter load value; unused when there are no wait states.
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    // ------------------------------------------------------------------
    // State and request capture registers
    // ------------------------------------------------------------------
    mmu_state_e        state_q,    state_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic [ADR_W-1:0]  addr_q,     addr_d;   // upper address bits wrap away
    logic [1:0]        width_q,    width_d;
    logic              signed_q,   signed_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              write_q,    write_d;
    logic              ready_q,    ready_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              mis_q,      mis_d;

    logic [31:0] mem_q [MEM_DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [31:0]      mem_word;
    logic [31:0]      rd_value;
    logic [31:0]      wr_word;
    logic             misaligned;
    logic             mem_we;

    assign word_idx = addr_q[ADR_W-1:2];
    assign mem_word = mem_q[word_idx];

    mmu_data_align u_align (
        .width_i      (width_q),
        .signed_i     (signed_q),
        .addr_lo_i    (addr_q[1:0]),
        .mem_word_i   (mem_word),
        .data_in_i    (wdata_q),
        .rd_data_o    (rd_value),
        .wr_word_o    (wr_word),
        .misaligned_o (misaligned)
    );

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= MMU_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            width_q    <= MMU_WIDTH_WORD;
            signed_q   <= 1'b0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            ready_q    <= 1'b0;
            data_out_q <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            width_q    <= width_d;
            signed_q   <= signed_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            ready_q    <= ready_d;
            data_out_q <= data_out_d;
            mis_q      <= mis_d;
        end
    end

    // The array is not reset. A reset forces state_q to IDLE, so a write
    // still waiting for its ACCESS edge is simply never performed.
    assign mem_we = (state_q == MMU_ACCESS) && write_q && !misaligned;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        width_d    = width_q;
        signed_d   = signed_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        ready_d    = ready_q;
        data_out_d = data_out_q;
        mis_d      = mis_q;

        case (state_q)
            MMU_IDLE: begin
                if (mmu_write_enable || mmu_read_enable) begin
                    addr_d   = mmu_address[ADR_W-1:0];
                    width_d  = mmu_mem_data_width;
                    signed_d = mmu_mem_signed_read;
                    wdata_d  = mmu_data_in;
                    write_d  = mmu_write_enable;
                    if (LATENCY > 0) begin
                        state_d = MMU_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = MMU_ACCESS;
                    end
                end
            end
            MMU_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = MMU_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MMU_ACCESS: begin
                ready_d = 1'b1;
                state_d = MMU_RESP;
                if (misaligned) begin
                    mis_d      = 1'b1;
                    data_out_d = 32'd0;
                end else begin
                    mis_d = 1'b0;
                    // Writes leave the last read data visible.
                    if (!write_q) begin
                        data_out_d = rd_value;
                    end
                end
            end
            MMU_RESP: begin
                ready_d = 1'b0;
                mis_d   = 1'b0;
                state_d = MMU_IDLE;
            end
            default: begin
                state_d = MMU_IDLE;
            end
        endcase
    end

    assign mmu_data_out   = data_out_q;
    assign mmu_mem_ready  = ready_q;
    assign mmu_misaligned = mis_q;

endmodule : mmu
`default_nettype wire

// File: tb/tb_mmu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmu
// Purpose : Self-checking bench for mmu. Instance 0 runs with LATENCY=2,
//           instance 1 with LATENCY=0; both share clock and reset. Expected
//           results come from a word-array reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mmu;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset_n;
    logic [1:0]  re, we, sg, rdy, mis;
    logic [1:0]  wd   [2];
    logic [31:0] ad   [2];
    logic [31:0] di   [2];
    logic [31:0] dout [2];

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] ref_mem  [2][DEPTH];
    logic [31:0] exp_dout [2];

    mmu #(.MEM_DEPTH_WORDS(DEPTH), .LATENCY(2), .INIT_FILE("")) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .mmu_read_enable(re[0]), .mmu_write_enable(we[0]),
        .mmu_mem_signed_read(sg[0]), .mmu_mem_data_width(wd[0]),
        .mmu_address(ad[0]), .mmu_data_in(di[0]),
        .mmu_data_out(dout[0]), .mmu_mem_ready(rdy[0]), .mmu_misaligned(mis[0])
    );

    mmu #(.MEM_DEPTH_WORDS(DEPTH), .LATENCY(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .mmu_read_enable(re[1]), .mmu_write_enable(we[1]),
        .mmu_mem_signed_read(sg[1]), .mmu_mem_data_width(wd[1]),
        .mmu_address(ad[1]), .mmu_data_in(di[1]),
        .mmu_data_out(dout[1]), .mmu_mem_ready(rdy[1]), .mmu_misaligned(mis[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: apply one request to the model memory and return the
    // expected misaligned flag and data_out after its completion.
    function automatic void model_req(input int d, input bit w_e, input bit s,
                                      input logic [1:0] w, input logic [31:0] a,
                                      input logic [31:0] din,
                                      output logic m, output logic [31:0] dv);
        int          size;
        int          idx;
        int          sh;
        logic [63:0] lmask;
        logic [63:0] v;
        size  = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        idx   = int'((a / 4) % DEPTH);
        sh    = 8 * int'(a % 4);
        lmask = (64'd1 << (8 * size)) - 64'd1;
        m     = ((a % size) != 0);
        if (m) begin
            exp_dout[d] = 32'd0;
        end else if (w_e) begin
            v = ({32'd0, ref_mem[d][idx]} & ~(lmask << sh)) | (({32'd0, din} & lmask) << sh);
            ref_mem[d][idx] = v[31:0];
        end else begin
            v = ({32'd0, ref_mem[d][idx]} >> sh) & lmask;
            if (s && size < 4 && v[8 * size - 1]) v = v | ~lmask;
            exp_dout[d] = v[31:0];
        end
        dv = exp_dout[d];
    endfunction

    // Wait (bounded) for the ready pulse; n = rising clock edges seen.
    task automatic wait_ready(input int d, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy[d] && n < 40);
        chk("ready_seen", 32'(rdy[d]), 32'd1);
    endtask

    task automatic req(input int d, input bit w_e, input bit r_e, input bit s,
                       input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] din, output logic [31:0] obs);
        int          n;
        logic        em;
        logic [31:0] ed;
        we[d] = w_e; re[d] = r_e; sg[d] = s; wd[d] = w; ad[d] = a; di[d] = din;
        wait_ready(d, n);
        model_req(d, w_e, s, w, a, din, em, ed);
        chk("latency", 32'(n), 32'(lat(d) + 2));
        chk("data_out", dout[d], ed);
        chk("misaligned", 32'(mis[d]), 32'(em));
        obs = dout[d];
        we[d] = 1'b0; re[d] = 1'b0;
        @(posedge clk); #1;
        chk("ready_pulse_len", 32'(rdy[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] o;
        int          n;

        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            re[d] = 1'b0; we[d] = 1'b0; sg[d] = 1'b0; wd[d] = 2'b10;
            ad[d] = 32'd0; di[d] = 32'd0; exp_dout[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(rdy[d]), 32'd0);
            chk("reset_dout", dout[d], 32'd0);
            chk("reset_mis", 32'(mis[d]), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Known contents, then a non-zero read so reset clearing is visible.
        req(0, 1, 0, 0, 2'b10, 32'h20, 32'h0000_0000, o);
        req(0, 1, 0, 0, 2'b10, 32'h14, 32'h0BAD_BEEF, o);
        req(0, 1, 0, 0, 2'b10, 32'h24, 32'hCAFE_F00D, o);
        req(0, 0, 1, 0, 2'b10, 32'h24, 32'h0, o);
        chk("plan_pre_reset_read", o, 32'hCAFE_F00D);

        // Reset while the write of 0x12345678 sits in WAIT.
        we[0] = 1'b1; wd[0] = 2'b10; ad[0] = 32'h20; di[0] = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        we[0] = 1'b0;
        #1;
        chk("midreset_ready", 32'(rdy[0]), 32'd0);
        chk("midreset_dout", dout[0], 32'd0);
        exp_dout[0] = 32'd0; exp_dout[1] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_ready_held", 32'(rdy[0]), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        req(0, 0, 1, 0, 2'b10, 32'h20, 32'h0, o);
        chk("plan_write_discarded", o, 32'h0000_0000);

        // Width and sign handling on LATENCY=2.
        req(0, 1, 0, 0, 2'b10, 32'h10, 32'h8899_AABB, o);
        req(0, 0, 1, 0, 2'b10, 32'h10, 32'h0, o);
        chk("plan_word", o, 32'h8899_AABB);
        req(0, 0, 1, 1, 2'b00, 32'h11, 32'h0, o);
        chk("plan_sbyte", o, 32'hFFFF_FFAA);
        req(0, 0, 1, 0, 2'b00, 32'h13, 32'h0, o);
        chk("plan_ubyte", o, 32'h0000_0088);
        req(0, 0, 1, 1, 2'b01, 32'h12, 32'h0, o);
        chk("plan_shalf", o, 32'hFFFF_8899);
        req(0, 0, 1, 0, 2'b01, 32'h10, 32'h0, o);
        chk("plan_uhalf", o, 32'h0000_AABB);
        req(0, 1, 0, 0, 2'b00, 32'h12, 32'h0000_007F, o);
        chk("plan_wr_holds_dout", o, 32'h0000_AABB);
        req(0, 0, 1, 0, 2'b10, 32'h10, 32'h0, o);
        chk("plan_byte_merge", o, 32'h887F_AABB);
        req(0, 0, 1, 0, 2'b01, 32'h11, 32'h0, o);
        chk("plan_mis_half_dout", o, 32'h0);
        req(0, 1, 0, 0, 2'b10, 32'h16, 32'hDEAD_0000, o);
        req(0, 0, 1, 0, 2'b10, 32'h14, 32'h0, o);
        chk("plan_mis_no_write", o, 32'h0BAD_BEEF);

        // LATENCY=0: preload 0..7, then a held-enable read stream.
        for (int k = 0; k < 8; k++) req(1, 1, 0, 0, 2'b10, 32'(k * 4), 32'(k), o);
        ad[1] = 32'h0; wd[1] = 2'b10; sg[1] = 1'b0; re[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic        em;
            logic [31:0] ed;
            wait_ready(1, n);
            chk(k == 0 ? "stream_latency" : "stream_period", 32'(n), k == 0 ? 32'd2 : 32'd3);
            model_req(1, 0, 0, 2'b10, 32'(k * 4), 32'h0, em, ed);
            chk("stream_data", dout[1], ed);
            chk("stream_order", dout[1], 32'(k));
            ad[1] = ad[1] + 32'd4;
        end
        re[1] = 1'b0;
        @(posedge clk); #1;
        req(1, 0, 1, 0, 2'b10, 32'(DEPTH * 4), 32'h0, o);
        chk("plan_wrap", o, 32'h0);

        // Randomized traffic against the model, with address aliasing.
        for (int i = 0; i < 16; i++) begin
            req(0, 1, 0, 0, 2'b10, 32'h200 + 32'(i * 4), $urandom, o);
            req(1, 1, 0, 0, 2'b10, 32'h200 + 32'(i * 4), $urandom, o);
        end
        for (int i = 0; i < 60; i++) begin
            int          d;
            int          op;
            logic [31:0] a;
            d  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            a  = 32'h200 + 32'($urandom_range(0, 63)) + 32'(DEPTH * 4) * 32'($urandom_range(0, 3));
            req(d, op == 1 || op == 2, op != 1, 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), a, $urandom, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mmu
`default_nettype wire
